mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 16, word-address width.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter MEM_DEPTH, 4096, words of attached memory; addresses >= MEM_DEPTH are out of range.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset; single clock domain.
REQ-005 SHALL have data request ports: d_req_valid in 1; d_req_ready out 1; d_req_we in 1; d_req_addr in ADDR_W; d_req_wdata in DATA_W.
REQ-006 SHALL have data response ports: d_rsp_valid out 1; d_rsp_ready in 1; d_rsp_rdata out DATA_W; d_rsp_err out 1.
REQ-007 SHALL have fetch ports, present only under the configuration macro: f_req_valid in 1; f_req_ready out 1; f_req_addr in ADDR_W; f_rsp_valid out 1; f_rsp_ready in 1; f_rsp_rdata out DATA_W; f_rsp_err out 1.
REQ-008 SHALL have memory-side ports: mem_addr out ADDR_W; mem_data_in out DATA_W; mem_we out 1; mem_re out 1; mem_data_out in DATA_W (registered memory output, valid the cycle after mem_re is sampled).
REQ-009 SHALL have busy out 1, high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-011 IDLE: req_ready high for each present port; a transfer occurs on valid&ready at a rising edge.
REQ-012 Accepted in-range request SHALL go to ISSUE with mem_addr, mem_data_in, and mem_we (write) or mem_re (read) driven for exactly one cycle.
REQ-013 ISSUE SHALL go to WAIT for reads and to RESP for writes; mem_we/mem_re low outside ISSUE.
REQ-014 WAIT SHALL capture mem_data_out into rsp_rdata and go to RESP; read rsp_valid rises 3 edges after acceptance.
REQ-015 Write response: rsp_valid rises 2 edges after acceptance; rsp_rdata = 0; rsp_err = 0.
REQ-016 Out-of-range address: no mem_we/mem_re pulse; go directly IDLE->RESP; rsp_err = 1; rsp_rdata = 0.
REQ-017 RESP SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready; on valid&ready return to IDLE; no new request accepted in the same cycle.
REQ-018 Only the response port of the granted requester SHALL assert rsp_valid; at most one outstanding request.
REQ-019 req_ready SHALL be low in ISSUE, WAIT, RESP.

Reset
REQ-020 rst asserted SHALL asynchronously force state IDLE; mem_we=0, mem_re=0, mem_addr=0, mem_data_in=0; all rsp_valid=0, rsp_rdata=0, rsp_err=0; busy=0; last-grant=fetch.
REQ-021 Reset mid-operation SHALL abandon the pending request; no response is produced after reset release.

Configuration
REQ-022 Macro MEMCTL_IFETCH_PORT_EN defined: fetch ports exist; fetch reads only; round-robin arbitration in IDLE.
REQ-023 With both valid, grant the port not granted last; single valid is granted immediately; the first tie after reset goes to data.
REQ-024 Macro undefined: fetch ports and arbiter absent; data port behaviour unchanged.

Structure
REQ-025 Shared package SHALL hold FSM state enum, ADDR_W/DATA_W/MEM_DEPTH defaults, and the grant-select encoding.
REQ-026 One sub-module, mem_rr_arb (2-way round-robin, last-grant register), SHALL be instantiated only under MEMCTL_IFETCH_PORT_EN.

Verification
REQ-027 Data write addr 20 wdata 0x0000000D, then read addr 20 -> one mem_we pulse; read rsp_rdata 0x0000000D, err 0, rsp_valid 3 edges after accept.
REQ-028 Read addr 21 with memory preloaded 0x00000011, d_rsp_ready held low 4 cycles -> rsp_valid/rdata stable 0x00000011; d_req_ready low until the handshake completes.
REQ-029 Read addr 0x1000 -> no mem_re pulse; d_rsp_err=1, rdata 0 one edge after accept.
REQ-030 (IFETCH_EN) Both ports valid continuously, addrs 22/23 -> grants alternate D,F,D,F; rdata 0x1, 0x2 on correct ports.
REQ-031 rst asserted in WAIT -> busy, mem_re, rsp_valid immediately 0; after release no stale response; next read addr 24 returns 0x00000005.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared definitions for the memory access controller slice:
//   - default ADDR_W / DATA_W / MEM_DEPTH values
//   - FSM state enumeration
//   - grant-select encoding used by the optional fetch-port arbiter
package mem_access_ctrl_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_DATA  = 1'b0,
    GNT_FETCH = 1'b1
  } gnt_sel_t;

endpackage

// File: rtl/mem_access_ctrl_arb.sv
// mem_rr_arb
// Two-way round-robin arbiter between the data and fetch requesters.
// Only instantiated when MEMCTL_IFETCH_PORT_EN is defined.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_d, req_f : data / fetch request valid
//   accept       : a request is being accepted this cycle (updates last grant)
//   grant_fetch  : 1 = fetch port wins, 0 = data port wins (combinational)
module mem_rr_arb
  import mem_access_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_d,
  input  logic req_f,
  input  logic accept,
  output logic grant_fetch
);

  gnt_sel_t last_q;
  gnt_sel_t gnt;

  always_comb begin
    if (req_d && req_f) begin
      gnt = (last_q == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (req_f) begin
      gnt = GNT_FETCH;
    end else begin
      gnt = GNT_DATA;
    end
  end

  assign grant_fetch = (gnt == GNT_FETCH);

  // Reset to "fetch granted last" so the first tie goes to the data port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_FETCH;
    end else if (accept) begin
      last_q <= gnt;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Single-outstanding memory access controller in front of a memory with a
// registered (one-cycle) read output. Optional instruction-fetch port with
// round-robin arbitration is enabled by defining MEMCTL_IFETCH_PORT_EN.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   d_req_*                        : data request (valid/ready, we, addr, wdata)
//   d_rsp_*                        : data response (valid/ready, rdata, err)
//   f_req_* / f_rsp_*              : fetch request/response (read-only, macro only)
//   mem_addr/mem_data_in/mem_we/
//   mem_re/mem_data_out            : memory side
//   busy                           : FSM not in IDLE
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              d_rsp_err,
`ifdef MEMCTL_IFETCH_PORT_EN
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_rsp_valid,
  input  logic              f_rsp_ready,
  output logic [DATA_W-1:0] f_rsp_rdata,
  output logic              f_rsp_err,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  state_t              state_q, state_nxt;
  logic                ready_q;
  logic [DATA_W-1:0]   rdata_q, rdata_nxt;
  logic                err_q, err_nxt;
  gnt_sel_t            sel_q, sel_nxt;
  logic                op_we_q, op_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_data_nxt;
  logic                mem_we_nxt, mem_re_nxt;
  logic                rsp_valid_nxt;

  // Muxed view of the granted requester.
  gnt_sel_t            gnt;
  logic                req_valid;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                rsp_ready_sel;
  logic                accept;
  logic                in_range;

`ifdef MEMCTL_IFETCH_PORT_EN
  logic grant_fetch;
  logic f_rsp_valid_q;

  mem_rr_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_d       (d_req_valid),
    .req_f       (f_req_valid),
    .accept      (accept),
    .grant_fetch (grant_fetch)
  );

  assign gnt           = grant_fetch ? GNT_FETCH : GNT_DATA;
  assign req_valid     = d_req_valid | f_req_valid;
  assign req_we        = (gnt == GNT_DATA) & d_req_we;
  assign req_addr      = (gnt == GNT_FETCH) ? f_req_addr : d_req_addr;
  assign req_wdata     = (gnt == GNT_DATA) ? d_req_wdata : '0;
  assign rsp_ready_sel = (sel_q == GNT_FETCH) ? f_rsp_ready : d_rsp_ready;
  // Registered IDLE-ready is masked for the port losing a tie, so a
  // requester never sees valid&ready without actually being accepted.
  assign d_req_ready   = ready_q & (gnt == GNT_DATA);
  assign f_req_ready   = ready_q & ~(d_req_valid & (gnt == GNT_DATA));
  assign f_rsp_valid   = f_rsp_valid_q;
  assign f_rsp_rdata   = rdata_q;
  assign f_rsp_err     = err_q;
`else
  assign gnt           = GNT_DATA;
  assign req_valid     = d_req_valid;
  assign req_we        = d_req_we;
  assign req_addr      = d_req_addr;
  assign req_wdata     = d_req_wdata;
  assign rsp_ready_sel = (sel_q == GNT_DATA) & d_rsp_ready;
  assign d_req_ready   = ready_q;
`endif

  assign d_rsp_rdata = rdata_q;
  assign d_rsp_err   = err_q;

  assign accept   = (state_q == IDLE) & req_valid;
  assign in_range = (32'(req_addr) < 32'(MEM_DEPTH));

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      d_rsp_valid <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      sel_q       <= GNT_DATA;
      op_we_q     <= 1'b0;
`ifdef MEMCTL_IFETCH_PORT_EN
      f_rsp_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_nxt;
      ready_q     <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      mem_addr    <= mem_addr_nxt;
      mem_data_in <= mem_data_nxt;
      mem_we      <= mem_we_nxt;
      mem_re      <= mem_re_nxt;
      d_rsp_valid <= rsp_valid_nxt & (sel_nxt == GNT_DATA);
      rdata_q     <= rdata_nxt;
      err_q       <= err_nxt;
      sel_q       <= sel_nxt;
      op_we_q     <= op_we_nxt;
`ifdef MEMCTL_IFETCH_PORT_EN
      f_rsp_valid_q <= rsp_valid_nxt & (sel_nxt == GNT_FETCH);
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept) state_nxt = in_range ? ISSUE : RESP;
      ISSUE:   state_nxt = op_we_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready_sel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    mem_addr_nxt  = mem_addr;
    mem_data_nxt  = mem_data_in;
    mem_we_nxt    = 1'b0;
    mem_re_nxt    = 1'b0;
    rdata_nxt     = rdata_q;
    err_nxt       = err_q;
    sel_nxt       = sel_q;
    op_we_nxt     = op_we_q;
    rsp_valid_nxt = (state_nxt == RESP);
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_nxt   = gnt;
          op_we_nxt = req_we;
          if (in_range) begin
            mem_addr_nxt = req_addr;
            mem_data_nxt = req_wdata;
            mem_we_nxt   = req_we;
            mem_re_nxt   = ~req_we;
          end else begin
            rdata_nxt = '0;
            err_nxt   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (op_we_q) begin
          rdata_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      WAIT: begin
        rdata_nxt = mem_data_out;
        err_nxt   = 1'b0;
      end
      RESP: begin
        if (rsp_ready_sel) begin
          rdata_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule
